// File: rtl/battle_pkg.sv
// Shared types for the Battle City scorekeeping stage: round-control FSM states,
// winner encoding and the 4-bit score type.
package battle_pkg;

  typedef enum logic [1:0] {
    StPlay = 2'd0,
    StHit  = 2'd1,
    StOver = 2'd2
  } state_e;

  typedef logic [3:0] score_t;
  typedef logic [1:0] winner_t;

  // Bit 0 flags player 1, bit 1 flags player 2; both set is a draw.
  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_P1   = 2'b01;
  localparam winner_t WIN_P2   = 2'b10;
  localparam winner_t WIN_DRAW = 2'b11;

endpackage

// File: rtl/frame_tick_gen.sv
// Recovers the frame rate from VGA vertical sync: one-cycle pulse on each rising edge of vs.
// Ports:
//   clk_i        - board clock
//   rst_ni       - asynchronous active-low reset
//   vs_i         - vertical sync, synchronous to clk_i
//   frame_tick_o - combinational rising-edge pulse of vs_i
module frame_tick_gen (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vs_i,
  output logic frame_tick_o
);

  logic vs_q;

  // Resets high so a vs already high when reset releases is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_i;
    end
  end

  assign frame_tick_o = vs_i & ~vs_q;

endmodule

// File: rtl/score_keeper.sv
// Scorekeeping and round control for Battle City. Counts debounced hits once per frame,
// freezes play during respawn and after the match ends, and reports scores and winner.
// Optional feature macro: SCORE_BLINK_EN enables the winner blink frame counter; without it
// blink is tied to 1.
// Ports:
//   Clk, Reset_n     - board clock, asynchronous active-low reset
//   vs               - VGA vertical sync (frame timing)
//   hit_t2, hit_t1   - intersect levels; rising edge scores for player 1 / player 2
//   restart_req      - one-cycle match restart pulse
//   score1, score2   - binary scores
//   freeze, respawn  - hold request and one-cycle respawn pulse to the game logic
//   game_over, winner, blink - match status and winner display controls
module score_keeper
  import battle_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES   = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       hit_t2,
  input  logic       hit_t1,
  input  logic       restart_req,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       freeze,
  output logic       respawn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       blink
);

  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("WIN_SCORE out of range");
  end
  if (RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255) begin : g_bad_respawn
    $error("RESPAWN_FRAMES out of range");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES out of range");
  end

  localparam score_t WinScore = score_t'(WIN_SCORE);

  logic frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .vs_i         (vs),
    .frame_tick_o (frame_tick)
  );

  state_e     state_q, state_d;
  score_t     s1_q, s1_d, s2_q, s2_d;
  logic [7:0] frz_q, frz_d;
  winner_t    winner_q, winner_d;
  logic       respawn_q, respawn_d;
  logic       h1_prev_q, h1_prev_d, h2_prev_q, h2_prev_d;

  // hit_t2 scores for player 1, hit_t1 for player 2.
  logic   ev_p1, ev_p2;
  score_t s1_inc, s2_inc;

  assign ev_p1  = hit_t2 & ~h2_prev_q;
  assign ev_p2  = hit_t1 & ~h1_prev_q;
  assign s1_inc = s1_q + score_t'(ev_p1);
  assign s2_inc = s2_q + score_t'(ev_p2);

  always_comb begin
    state_d   = state_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    frz_d     = frz_q;
    winner_d  = winner_q;
    respawn_d = 1'b0;
    h1_prev_d = h1_prev_q;
    h2_prev_d = h2_prev_q;
    if (restart_req) begin
      // Capture current levels so a hit already overlapping at restart does not score.
      state_d   = StPlay;
      s1_d      = '0;
      s2_d      = '0;
      frz_d     = '0;
      winner_d  = WIN_NONE;
      respawn_d = 1'b1;
      h1_prev_d = hit_t1;
      h2_prev_d = hit_t2;
    end else if (frame_tick) begin
      h1_prev_d = hit_t1;
      h2_prev_d = hit_t2;
      unique case (state_q)
        StPlay: begin
          if (ev_p1 || ev_p2) begin
            s1_d = s1_inc;
            s2_d = s2_inc;
            if (s1_inc == WinScore || s2_inc == WinScore) begin
              state_d  = StOver;
              winner_d = {s2_inc == WinScore, s1_inc == WinScore};
            end else begin
              state_d = StHit;
              frz_d   = 8'(RESPAWN_FRAMES);
            end
          end
        end
        StHit: begin
          frz_d = frz_q - 8'd1;
          if (frz_q == 8'd1) begin
            state_d   = StPlay;
            respawn_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StPlay;
      s1_q      <= '0;
      s2_q      <= '0;
      frz_q     <= '0;
      winner_q  <= WIN_NONE;
      respawn_q <= 1'b0;
      h1_prev_q <= 1'b0;
      h2_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      frz_q     <= frz_d;
      winner_q  <= winner_d;
      respawn_q <= respawn_d;
      h1_prev_q <= h1_prev_d;
      h2_prev_q <= h2_prev_d;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (restart_req || (state_q != StOver && state_d == StOver)) begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (frame_tick && state_q == StOver) begin
      if (bcnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  assign score1    = s1_q;
  assign score2    = s2_q;
  assign freeze    = (state_q != StPlay);
  assign game_over = (state_q == StOver);
  assign respawn   = respawn_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int WIN   = 5;
  localparam int RESP  = 60;
  localparam int BLINK = 30;

  localparam int PH_PLAY = 0;
  localparam int PH_HIT  = 1;
  localparam int PH_OVER = 2;

  logic       Clk, Reset_n, vs, hit_t2, hit_t1, restart_req;
  logic [3:0] score1, score2;
  logic       freeze, respawn, game_over, blink;
  logic [1:0] winner;

  score_keeper #(
    .WIN_SCORE      (WIN),
    .RESPAWN_FRAMES (RESP),
    .BLINK_FRAMES   (BLINK)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vs          (vs),
    .hit_t2      (hit_t2),
    .hit_t1      (hit_t1),
    .restart_req (restart_req),
    .score1      (score1),
    .score2      (score2),
    .freeze      (freeze),
    .respawn     (respawn),
    .game_over   (game_over),
    .winner      (winner),
    .blink       (blink)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int resp_seen = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference model: game rules at frame granularity, plain integers.
  typedef struct {
    int s1;
    int s2;
    int phase;
    int frz;
    bit resp;
    int win;
    bit vs_prev;
    bit p1_prev;
    bit p2_prev;
    bit blink;
    int bcnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.s1 = 0; r.s2 = 0; r.phase = PH_PLAY; r.frz = 0; r.resp = 0; r.win = 0;
    r.vs_prev = 1; r.p1_prev = 0; r.p2_prev = 0; r.blink = 1; r.bcnt = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, bit v, bit t1, bit t2, bit rr);
    mdl_t n;
    bit   tick, e1, e2;
    n = c;
    tick = v && !c.vs_prev;
    n.vs_prev = v;
    n.resp = 0;
    e1 = t2 && !c.p2_prev;
    e2 = t1 && !c.p1_prev;
    if (rr) begin
      n.s1 = 0; n.s2 = 0; n.win = 0; n.phase = PH_PLAY; n.frz = 0; n.resp = 1;
      n.p1_prev = t1; n.p2_prev = t2; n.blink = 1; n.bcnt = 0;
    end else if (tick) begin
      n.p1_prev = t1;
      n.p2_prev = t2;
      if (c.phase == PH_PLAY && (e1 || e2)) begin
        n.s1 = c.s1 + (e1 ? 1 : 0);
        n.s2 = c.s2 + (e2 ? 1 : 0);
        if (n.s1 == WIN || n.s2 == WIN) begin
          n.phase = PH_OVER;
          n.win = (n.s1 == WIN ? 1 : 0) + (n.s2 == WIN ? 2 : 0);
          n.blink = 1;
          n.bcnt = 0;
        end else begin
          n.phase = PH_HIT;
          n.frz = RESP;
        end
      end else if (c.phase == PH_HIT) begin
        n.frz = c.frz - 1;
        if (n.frz == 0) begin
          n.phase = PH_PLAY;
          n.resp = 1;
        end
      end else if (c.phase == PH_OVER) begin
        n.bcnt = c.bcnt + 1;
        if (n.bcnt == BLINK) begin
          n.bcnt = 0;
          n.blink = !c.blink;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [13:0] exp_vec(mdl_t c);
    logic b;
`ifdef SCORE_BLINK_EN
    b = c.blink;
`else
    b = 1'b1;
`endif
    return {4'(c.s1), 4'(c.s2), c.phase != PH_PLAY, c.resp, c.phase == PH_OVER, 2'(c.win), b};
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m <= mdl_reset();
    else m <= mdl_step(m, vs, hit_t1, hit_t2, restart_req);
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cycle", int'({score1, score2, freeze, respawn, game_over, winner, blink}),
            int'(exp_vec(m)));
      if (respawn) resp_seen++;
    end
  end

  // One frame: tick on the first edge, then three quiet cycles.
  task automatic frame(input bit t1, input bit t2);
    hit_t1 = t1;
    hit_t2 = t2;
    vs = 1'b1;
    @(posedge Clk); #2;
    vs = 1'b0;
    repeat (3) begin @(posedge Clk); #2; end
  endtask

  task automatic score_hit(input bit t1, input bit t2);
    frame(t1, t2);
    repeat (RESP) frame(1'b0, 1'b0);
  endtask

  task automatic restart_pulse();
    restart_req = 1'b1;
    @(posedge Clk); #2;
    restart_req = 1'b0;
  endtask

  initial begin
    int r0;
    Reset_n = 1'b1; vs = 1'b0; hit_t1 = 1'b0; hit_t2 = 1'b0; restart_req = 1'b0;
    #3 Reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #2;

    // Reset values
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_freeze", freeze, 0);
    check("rst_winner", winner, 0);
    check("rst_blink", blink, 1);

    // Idle frames
    repeat (3) frame(1'b0, 1'b0);
    check("idle_scores", {score1, score2}, 0);
    check("idle_game_over", game_over, 0);
    check("idle_freeze", freeze, 0);

    // hit_t2 held across 5 frames scores once, then 60-tick freeze
    r0 = resp_seen;
    repeat (5) frame(1'b0, 1'b1);
    repeat (RESP - 5) frame(1'b0, 1'b0);
    check("held_score1", score1, 1);
    check("held_score2", score2, 0);
    check("freeze_tick59", freeze, 1);
    check("no_respawn_yet", resp_seen - r0, 0);
    frame(1'b0, 1'b0);
    check("freeze_tick60", freeze, 0);
    check("one_respawn", resp_seen - r0, 1);

    // Bring scores to 4/4, then simultaneous hits
    repeat (3) score_hit(1'b0, 1'b1);
    repeat (4) score_hit(1'b1, 1'b0);
    check("pre_draw", {score1, score2}, 8'h44);
    frame(1'b1, 1'b1);
    check("draw_scores", {score1, score2}, 8'h55);
    check("draw_over", game_over, 1);
    check("draw_winner", winner, 3);
    frame(1'b0, 1'b0);

    // Restart coincident with a tick and a rising hit_t2 while in OVER
    hit_t2 = 1'b1; vs = 1'b1; restart_req = 1'b1;
    @(posedge Clk); #2;
    restart_req = 1'b0; vs = 1'b0;
    check("restart_scores", {score1, score2}, 0);
    check("restart_respawn", respawn, 1);
    check("restart_freeze", freeze, 0);
    check("restart_winner", winner, 0);
    @(posedge Clk); #2;
    check("restart_respawn_off", respawn, 0);
    repeat (2) begin @(posedge Clk); #2; end
    frame(1'b0, 1'b1);
    check("stale_hit_ignored", score1, 0);
    frame(1'b0, 1'b0);

    // Player 2 wins with five separated hits
    repeat (4) score_hit(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check("p2_score", score2, 5);
    check("p2_winner", winner, 2);
    check("p2_freeze", freeze, 1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    frame(1'b1, 1'b0);
    check("over_held", {score1, score2}, 8'h05);

    // Randomized play, including restarts in every state
    restart_pulse();
    for (int i = 0; i < 700; i++) begin
      bit a, b;
      a = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          hit_t1 = a; hit_t2 = b; vs = 1'b1; restart_req = 1'b1;
          @(posedge Clk); #2;
          restart_req = 1'b0; vs = 1'b0;
          repeat (3) begin @(posedge Clk); #2; end
        end else begin
          restart_pulse();
        end
      end
      frame(a, b);
    end

    // Asynchronous reset mid-HIT
    restart_pulse();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    repeat (30) frame(1'b0, 1'b0);
    check("pre_reset_freeze", freeze, 1);
    check("pre_reset_score1", score1, 1);
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    check("async_scores", {score1, score2}, 0);
    check("async_freeze", freeze, 0);
    check("async_game_over", game_over, 0);
    check("async_winner", winner, 0);
    check("async_respawn", respawn, 0);
    check("async_blink", blink, 1);
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    @(posedge Clk); #2;
    frame(1'b0, 1'b0);
    check("post_reset_play", freeze, 0);
    frame(1'b0, 1'b1);
    check("post_reset_hit", score1, 1);
    check("post_reset_hit_freeze", freeze, 1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Scorekeeping and round-control stage directly downstream of the game-logic block in the Battle City top level. Consumes the two bullet/tank intersect flags plus VGA vertical sync, counts debounced hits per player once per frame, freezes play during respawn and at match end, and produces score digits for the HEX drivers plus freeze/respawn controls back to the game logic. Fully synchronous to the 50 MHz board clock; frame rate is recovered internally from `vs`.

## Interface
- `WIN_SCORE`, default 5: hits needed to win; range 1..15.
- `RESPAWN_FRAMES`, default 60: frames frozen after a hit; range 1..255.
- `BLINK_FRAMES`, default 30: half-period of `blink`, in frames; used only with `SCORE_BLINK_EN`.

Ports:
- `Clk` in 1: 50 MHz board clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `vs` in 1: VGA vertical sync from the VGA controller, synchronous to `Clk`.
- `hit_t2` in 1: Bullet1_Tank2_intersect level; a rising edge scores for player 1.
- `hit_t1` in 1: Bullet2_Tank1_intersect level; a rising edge scores for player 2.
- `restart_req` in 1: one-cycle pulse that restarts the match.
- `score1` out 4: player 1 score, binary.
- `score2` out 4: player 2 score, binary.
- `freeze` out 1: game logic must hold tanks and bullets while this is 1.
- `respawn` out 1: one-cycle pulse; game logic returns tanks to start positions.
- `game_over` out 1: match finished.
- `winner` out 2: 00 none, 01 player 1, 10 player 2, 11 draw.
- `blink` out 1: winner-display blink enable.

## Operation
- Frame tick:
  - `vs_q` registers `vs`.
  - `frame_tick = vs & ~vs_q`, which is the rising edge of `vs`.
  - All game state advances only on cycles where `frame_tick` = 1.
- Hit sampling:
  - On each `frame_tick`, `hit_t1` and `hit_t2` are registered into `h1_prev` and `h2_prev`.
  - A hit event is `hit_tN & ~hN_prev` evaluated at the tick.
  - A level held across many frames counts exactly once.
- FSM states:
  - **PLAY**
    - On a tick with any hit event, each flagged score increments.
    - If any score now equals `WIN_SCORE`, go to OVER; otherwise go to HIT and load `frz_cnt = RESPAWN_FRAMES`.
  - **HIT**
    - `frz_cnt` decrements on each tick; hit events are ignored.
    - On the tick where `frz_cnt` = 1: pulse `respawn` and go to PLAY.
  - **OVER**
    - Scores are held and all hits are ignored.
    - Leaves only via `restart_req` or reset.
- Simultaneous hits in one tick: both scores increment. If both reach `WIN_SCORE`, `winner` = 11.
- `winner` is set on entry to OVER and held there. It is 00 in every other state.
- `restart_req`:
  - Accepted in any state and has priority over a same-cycle `frame_tick`.
  - Effect: scores to 0, `winner` to 00, FSM to PLAY, `respawn` pulsed in the same cycle, and `h*_prev` loaded with the current hit levels so a stale overlap does not score.
- `freeze` = 1 in HIT and OVER, 0 in PLAY.
- Scores never exceed `WIN_SCORE`. The width is fixed at 4 bits; no wrap can occur.

## Timing
- Reset values:
  - FSM = PLAY; `score1` = `score2` = 0.
  - `freeze` = 0, `respawn` = 0, `game_over` = 0, `winner` = 00.
  - `blink` = 1; `vs_q` = 1, which suppresses a false tick after reset.
  - `frz_cnt` = 0; `h*_prev` = 0.
- Latency:
  - `vs` rise to `frame_tick`: 0 cycles (combinational from `vs`, `vs_q`).
  - `frame_tick` to updated score, `freeze`, `winner` or `game_over`: 1 cycle. All outputs are registered.
- `respawn` is high for exactly one `Clk` cycle per HIT exit or restart.
- Reset asserted mid-match returns all state to reset values immediately (asynchronously). Operation resumes on the first tick after `Reset_n` deasserts.

## Configuration
- `SCORE_BLINK_EN` defined:
  - A frame counter toggles `blink` every `BLINK_FRAMES` ticks while in OVER.
  - Entering OVER or restarting sets `blink` = 1 and clears the counter.
- Not defined: `blink` is tied to 1 and no counter is generated.

## Structure
- Shared package `battle_pkg` holds:
  - the FSM state enum: PLAY, HIT, OVER;
  - the `winner` encoding constants: WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW;
  - the 4-bit score type.
- One natural sub-module, `frame_tick_gen`: `vs` edge detector producing `frame_tick`.
- The FSM and counters live in `score_keeper`.

## Test plan
- Reset, then 3 `vs` pulses with no hits → scores 0/0, `freeze` = 0, `winner` = 00, `game_over` = 0.
- `hit_t2` held high across 5 frames in PLAY → `score1` = 1 only; `freeze` = 1 for 60 ticks; a single `respawn` pulse on the 60th tick; `freeze` = 0 afterwards.
- `hit_t1` and `hit_t2` rise on the same tick with scores 4/4 → both scores = 5, `game_over` = 1, `winner` = 11.
- Five separated `hit_t1` events, each after its respawn → `score2` = 5, `winner` = 10, `freeze` = 1; further hits leave the scores unchanged.
- `restart_req` on the same cycle as a `frame_tick` with `hit_t2` rising, in OVER → scores 0/0, PLAY, `respawn` = 1 for one cycle, no score from that hit.
- `Reset_n` pulsed low mid-HIT with `frz_cnt` = 30 → all outputs return to reset values asynchronously; the first tick after release is in PLAY.
